// File: rtl/uart_hex_tx.sv
// uart_hex_tx: prints each accepted result byte as "HH\r\n" on an 8N1 UART.
// Bytes are queued in a small FIFO; a single FSM pops one byte at a time and
// shifts out its four ASCII characters LSB first, idle-high line.
module uart_hex_tx #(
  parameter int CLK_DIV    = 100,  // clk cycles per UART bit, >= 2
  parameter int FIFO_DEPTH = 4     // power of 2, >= 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_vld,
  output logic       fifo_full,
  output logic       ovf,
  output logic       tx_busy,
  output logic       tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLK_DIV);

  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ASCII hex digit for one nibble, uppercase letters.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] n8;
    n8 = {4'h0, n};
    if (n < 4'd10) begin
      return 8'h30 + n8;
    end
    return 8'h41 + (n8 - 8'd10);
  endfunction

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             fifo_full_reg;
  logic             ovf_reg;
  logic             push;
  logic             pop;

  state_t           state_reg;

  // Full is judged on the registered flag only, so a push arriving while full
  // is rejected even if the FSM frees a slot in that same cycle.
  assign push = data_vld && !fifo_full_reg;
  assign pop  = (state_reg == ST_IDLE) && (count_reg != '0);

  // Occupancy after this cycle's push/pop; simultaneous push and pop cancel.
  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (!push && pop) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  // Storage array: write port only, contents need no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg[wr_ptr_reg] <= data_in;
    end
  end

  // Pointers, occupancy, full flag and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      fifo_full_reg <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      // Pointers are exactly PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg     <= count_next;
      fifo_full_reg <= (count_next == CNT_FULL);
      if (data_vld && fifo_full_reg) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame contents
  // ---------------------------------------------------------------------------
  logic [7:0] frame_byte_reg;
  logic [7:0] frame_chars [4];
  logic [1:0] char_idx_reg;
  logic [7:0] cur_char;

  // Registered read of the head entry; the byte stays put for the whole frame.
  always_ff @(posedge clk) begin
    if (pop) begin
      frame_byte_reg <= mem_reg[rd_ptr_reg];
    end
  end

  // Characters 0 and 1 are the high and low nibble in hex; 2 and 3 are CR, LF.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hex_chars
      assign frame_chars[gi] = hex_ascii(frame_byte_reg[7-4*gi -: 4]);
    end
  endgenerate
  assign frame_chars[2] = 8'h0D;
  assign frame_chars[3] = 8'h0A;

  assign cur_char = frame_chars[char_idx_reg];

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_idx_reg;
  logic              tx_reg;
  logic              tx_busy_reg;
  logic              baud_done;

  assign baud_done = (baud_reg == BAUD_LAST);

  // Bit-timed state machine; tx is registered and set one cycle ahead of each
  // bit period so the line changes exactly on the state/bit boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      baud_reg     <= '0;
      bit_idx_reg  <= '0;
      char_idx_reg <= '0;
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          baud_reg <= '0;
          if (pop) begin
            char_idx_reg <= '0;
            bit_idx_reg  <= '0;
            tx_busy_reg  <= 1'b1;
            tx_reg       <= 1'b0;
            state_reg    <= ST_START;
          end
        end

        ST_START: begin
          if (baud_done) begin
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            tx_reg      <= cur_char[0];
            state_reg   <= ST_DATA;
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= cur_char[bit_idx_reg + 3'd1];
            end
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (baud_done) begin
            baud_reg <= '0;
            if (char_idx_reg == 2'd3) begin
              // Busy drops here; IDLE may pop again in the very next cycle.
              tx_busy_reg <= 1'b0;
              state_reg   <= ST_IDLE;
            end else begin
              char_idx_reg <= char_idx_reg + 2'd1;
              tx_reg       <= 1'b0;
              state_reg    <= ST_START;
            end
          end else begin
            baud_reg <= baud_reg + BAUD_W'(1);
          end
        end

        default: begin
          baud_reg    <= '0;
          tx_reg      <= 1'b1;
          tx_busy_reg <= 1'b0;
          state_reg   <= ST_IDLE;
        end
      endcase
    end
  end

  assign fifo_full = fifo_full_reg;
  assign ovf       = ovf_reg;
  assign tx_busy   = tx_busy_reg;
  assign tx        = tx_reg;

endmodule

// File: tb/tb_uart_hex_tx.sv
// Testbench for uart_hex_tx: a UART receiver model decodes tx into bytes,
// which are compared against hand-written vector tables and against a text
// model ("HH\r\n" per accepted byte) for randomized bursts.
module tb_uart_hex_tx;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int HALF       = CLK_DIV / 2;
  localparam int FRAME_CLK  = 4 * 10 * CLK_DIV;
  localparam int TMO        = 7 * FRAME_CLK + 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_vld = 1'b0;
  logic       fifo_full;
  logic       ovf;
  logic       tx_busy;
  logic       tx;

  int n_checks = 0;
  int n_errors = 0;

  uart_hex_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .data_vld  (data_vld),
    .fifo_full (fifo_full),
    .ovf       (ovf),
    .tx_busy   (tx_busy),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // UART receiver model (samples mid-bit on falling clk edges)
  // ---------------------------------------------------------------------------
  logic       rst_seen  = 1'b1;
  logic       rx_active = 1'b0;
  int         rx_cnt    = 0;
  logic [7:0] rx_shift  = 8'h00;
  int         stop_err  = 0;
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];

  always @(posedge clk) rst_seen <= rst;

  always @(negedge clk) begin
    if (rst_seen) begin
      rx_active <= 1'b0;
      rx_cnt    <= 0;
    end else if (!rx_active) begin
      if (tx == 1'b0) begin
        rx_active <= 1'b1;
        rx_cnt    <= 1;
      end
    end else begin
      rx_cnt <= rx_cnt + 1;
      if (rx_cnt == HALF) begin
        if (tx !== 1'b0) rx_active <= 1'b0;
      end else if (rx_cnt > HALF && ((rx_cnt - HALF) % CLK_DIV) == 0) begin
        if ((rx_cnt - HALF) / CLK_DIV <= 8) begin
          rx_shift[3'((rx_cnt - HALF) / CLK_DIV - 1)] <= tx;
        end else begin
          if (tx !== 1'b1) stop_err <= stop_err + 1;
          rx_q.push_back(rx_shift);
          rx_active <= 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_hex(input logic [3:0] n);
    string digits;
    digits = "0123456789ABCDEF";
    return digits[n];
  endfunction

  // Reference text for one accepted byte.
  task automatic model_frame(input logic [7:0] b);
    exp_q.push_back(model_hex(b[7:4]));
    exp_q.push_back(model_hex(b[3:0]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    data_vld = 1'b1;
    data_in  = b;
    @(negedge clk);
    data_vld = 1'b0;
    data_in  = 8'($urandom);
  endtask

  // Wait until line, FSM and receiver have all been idle for two bit times.
  task automatic wait_quiet(input string name);
    int q;
    int t;
    q = 0;
    t = 0;
    while (q < 2 * CLK_DIV && t < TMO) begin
      @(negedge clk);
      t++;
      if (!tx_busy && !rx_active && tx === 1'b1) q++;
      else q = 0;
    end
    check({name, "_quiet_in_time"}, 32'(t < TMO), 32'd1);
  endtask

  task automatic compare_text(input string name);
    $display("text %s: %0d bytes received, %0d expected", name, rx_q.size(), exp_q.size());
    check({name, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s_byte%0d", name, i),
            (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF, 32'(exp_q[i]));
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table: byte and its two expected hex characters
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [7:0] data;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  vec_t vecs [11];

  int         t;
  int         cnt;
  int         len;
  logic       exp_ovf;
  logic [7:0] b;

  initial begin
    vecs[0]  = '{8'h3A, 8'h33, 8'h41};  // "3A"
    vecs[1]  = '{8'd0,  8'h30, 8'h30};  // "00"
    vecs[2]  = '{8'd1,  8'h30, 8'h31};  // "01"
    vecs[3]  = '{8'd1,  8'h30, 8'h31};  // "01"
    vecs[4]  = '{8'd2,  8'h30, 8'h32};  // "02"
    vecs[5]  = '{8'd3,  8'h30, 8'h33};  // "03"
    vecs[6]  = '{8'd5,  8'h30, 8'h35};  // "05"
    vecs[7]  = '{8'd8,  8'h30, 8'h38};  // "08"
    vecs[8]  = '{8'd13, 8'h30, 8'h44};  // "0D"
    vecs[9]  = '{8'd21, 8'h31, 8'h35};  // "15"
    vecs[10] = '{8'd34, 8'h32, 8'h32};  // "22"

    // ---- reset state ----
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    // ---- test 1: 0x3A, latency and busy length ----
    rx_q.delete();
    push(vecs[0].data);
    check("t1_tx_pop_cycle", 32'(tx), 32'd1);
    check("t1_busy_pop_cycle", 32'(tx_busy), 32'd0);
    @(negedge clk);
    check("t1_tx_start", 32'(tx), 32'd0);
    check("t1_busy_start", 32'(tx_busy), 32'd1);
    cnt = 1;
    t = 0;
    while (tx_busy && t < TMO) begin
      @(negedge clk);
      t++;
      if (tx_busy) cnt++;
    end
    check("t1_busy_cycles", 32'(cnt), 32'(FRAME_CLK));
    cnt = 0;
    repeat (3 * CLK_DIV) begin
      @(negedge clk);
      if (tx !== 1'b1) cnt++;
    end
    check("t1_tx_idle_after", 32'(cnt), 32'd0);
    wait_quiet("t1");
    exp_q.push_back(vecs[0].c0);
    exp_q.push_back(vecs[0].c1);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    compare_text("t1");

    // ---- test 2: Fibonacci table, one byte per frame ----
    for (int i = 1; i < 11; i++) begin
      push(vecs[i].data);
      wait_quiet($sformatf("t2_v%0d", i));
      exp_q.push_back(vecs[i].c0);
      exp_q.push_back(vecs[i].c1);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      compare_text($sformatf("t2_v%0d", i));
    end
    check("t2_ovf", 32'(ovf), 32'd0);

    // ---- test 3: six back-to-back strobes, last one overflows ----
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 4) check("t3_full_5th", 32'(fifo_full), 32'd0);
      if (i == 5) check("t3_full_6th", 32'(fifo_full), 32'd1);
      data_vld = 1'b1;
      data_in  = 8'(8'h11 + i);
    end
    @(negedge clk);
    data_vld = 1'b0;
    check("t3_ovf", 32'(ovf), 32'd1);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (tx_busy && t < TMO) begin
        @(negedge clk);
        t++;
      end
      cnt = 0;
      while (!tx_busy && cnt < 4 * CLK_DIV) begin
        @(negedge clk);
        cnt++;
      end
      check($sformatf("t3_gap%0d", k), 32'(cnt), 32'd1);
    end
    wait_quiet("t3");
    for (int i = 0; i < 5; i++) model_frame(8'(8'h11 + i));
    compare_text("t3");

    // ---- test 4: reset during a data bit of char1 ----
    push(8'h7E);
    t = 0;
    while (tx === 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("t4_tx_started", 32'(tx), 32'd0);
    repeat (14 * CLK_DIV + HALF) @(negedge clk);
    check("t4_busy_before_rst", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t4_tx_after_rst", 32'(tx), 32'd1);
    check("t4_busy_after_rst", 32'(tx_busy), 32'd0);
    cnt = 0;
    repeat (12 * CLK_DIV) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) cnt++;
    end
    check("t4_silent_after_rst", 32'(cnt), 32'd0);
    check("t4_ovf_cleared", 32'(ovf), 32'd0);
    check("t4_full_cleared", 32'(fifo_full), 32'd0);
    exp_q.push_back(8'h37);  // only char0 '7' completed before the abort
    compare_text("t4_abort");
    push(8'h05);
    wait_quiet("t4_after");
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    compare_text("t4_after");

    // ---- test 5: AF, FF, 00 on consecutive cycles ----
    foreach (vecs[i]) if (i < 0) b = 8'h00;  // no-op guard for lint of unused loop form
    @(negedge clk); data_vld = 1'b1; data_in = 8'hAF;
    @(negedge clk); data_in = 8'hFF;
    @(negedge clk); data_in = 8'h00;
    @(negedge clk); data_vld = 1'b0;
    wait_quiet("t5");
    model_frame(8'hAF);
    model_frame(8'hFF);
    model_frame(8'h00);
    compare_text("t5");
    check("t5_stop_bits", 32'(stop_err), 32'd0);

    // ---- test 6: strobe while full with a pop in the same cycle ----
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      data_vld = 1'b1;
      data_in  = 8'(8'h61 + i);
    end
    @(negedge clk);
    data_vld = 1'b0;
    t = 0;
    while (tx_busy && t < TMO) begin
      @(negedge clk);
      t++;
    end
    check("t6_full_at_pop", 32'(fifo_full), 32'd1);
    data_vld = 1'b1;
    data_in  = 8'hEE;
    @(negedge clk);
    check("t6_ovf", 32'(ovf), 32'd1);
    check("t6_full_after_pop", 32'(fifo_full), 32'd0);
    data_in = 8'h66;
    @(negedge clk);
    data_vld = 1'b0;
    check("t6_full_refilled", 32'(fifo_full), 32'd1);
    wait_quiet("t6");
    for (int i = 0; i < 6; i++) model_frame(8'(8'h61 + i));
    compare_text("t6");
    exp_ovf = 1'b1;

    // ---- randomized bursts against the text model ----
    // From an idle, empty state the first byte is popped while the second is
    // written, so FIFO_DEPTH+1 consecutive strobes fit; later ones are dropped.
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++) begin
        @(negedge clk);
        b = 8'($urandom);
        data_vld = 1'b1;
        data_in  = b;
        if (i < FIFO_DEPTH + 1) model_frame(b);
        else exp_ovf = 1'b1;
      end
      @(negedge clk);
      data_vld = 1'b0;
      data_in  = 8'($urandom);
      wait_quiet($sformatf("rnd%0d", r));
      compare_text($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_ovf", r), 32'(ovf), 32'(exp_ovf));
    end
    check("final_stop_bits", 32'(stop_err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
